// File: rtl/seg_msg_scheduler.sv
// rtl/seg_msg_scheduler.sv - shares the two-digit 7-segment message path between speed, error and freq requesters
//
// Requests are latched as pending flags every cycle. In IDLE they are served
// by fixed priority (error > speed > freq). An idle timeout blanks the display
// to EMPTY. Speed is converted to two BCD digits by repeated subtraction of 10.
// Each message is put on o_msg one cycle before a NOTI_W-wide o_noti strobe.
// It is then held for HOLD_CYCLES before the next request may be served.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   i_speed_valid  one-cycle pulse, i_speed_val valid
//   i_speed_val    unsigned binary speed 0..255
//   i_err_req      one-cycle pulse requesting ERROR
//   i_freq_req     one-cycle pulse requesting FREQ
//   o_msg          decoder message: [7:4] left code, [3:0] right code
//   o_noti         decoder latch strobe
//   o_busy         high in every state except IDLE

module seg_msg_scheduler #(
    parameter int HOLD_CYCLES  = 50000,
    parameter int NOTI_W       = 2,
    parameter int LOW_TH       = 5,
    parameter int IDLE_TIMEOUT = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_speed_valid,
    input  logic [7:0] i_speed_val,
    input  logic       i_err_req,
    input  logic       i_freq_req,
    output logic [7:0] o_msg,
    output logic       o_noti,
    output logic       o_busy
);

    localparam int CNT_MAX = (HOLD_CYCLES > NOTI_W) ? HOLD_CYCLES : NOTI_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDLE_W  = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  NOTI_LAST = CNT_W'(NOTI_W - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [7:0]        LOW_TH8   = 8'(LOW_TH);

    localparam logic [7:0] MSG_EMPTY = 8'hAA;
    localparam logic [7:0] MSG_HIGH  = 8'hBB;
    localparam logic [7:0] MSG_LOW   = 8'hCC;
    localparam logic [7:0] MSG_FREQ  = 8'hDD;
    localparam logic [7:0] MSG_ERROR = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_LOAD,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_err_pend;
    logic              r_freq_pend;
    logic              r_spd_pend;
    logic [7:0]        r_spd_reg;
    logic [7:0]        r_rem;
    logic [3:0]        r_tens;
    logic              r_first;
    logic [7:0]        r_msg;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDLE_W-1:0] r_idle_cnt;

    logic              w_err_acc;
    logic              w_spd_acc;
    logic              w_freq_acc;
    logic              w_load;
    logic [7:0]        w_sel;
    logic              w_sub;
    logic              w_idle_inc;

    // Next-state and datapath controls. o_msg is written on the edge that
    // enters LOAD, so it is stable for the whole LOAD cycle before o_noti.
    always_comb begin
        w_state_nxt = r_state;
        w_err_acc   = 1'b0;
        w_spd_acc   = 1'b0;
        w_freq_acc  = 1'b0;
        w_load      = 1'b0;
        w_sel       = r_msg;
        w_sub       = 1'b0;
        w_idle_inc  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_err_pend) begin
                    w_err_acc   = 1'b1;
                    w_sel       = MSG_ERROR;
                    w_load      = 1'b1;
                    w_state_nxt = S_LOAD;
                end else if (r_spd_pend) begin
                    w_spd_acc   = 1'b1;
                    w_state_nxt = S_CONVERT;
                end else if (r_freq_pend) begin
                    w_freq_acc  = 1'b1;
                    w_sel       = MSG_FREQ;
                    w_load      = 1'b1;
                    w_state_nxt = S_LOAD;
                end else if (r_msg != MSG_EMPTY) begin
                    // Once EMPTY is shown the timer parks, so EMPTY is never re-sent.
                    if (r_idle_cnt == IDLE_LAST) begin
                        w_sel       = MSG_EMPTY;
                        w_load      = 1'b1;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_idle_inc = 1'b1;
                    end
                end
            end
            S_CONVERT: begin
                if (r_first) begin
                    // Classification cycle; in-range values fall through to the loop.
                    if (r_rem > 8'd99) begin
                        w_sel       = MSG_HIGH;
                        w_load      = 1'b1;
                        w_state_nxt = S_LOAD;
                    end else if (r_rem < LOW_TH8) begin
                        w_sel       = MSG_LOW;
                        w_load      = 1'b1;
                        w_state_nxt = S_LOAD;
                    end
                end else if (r_rem >= 8'd10) begin
                    w_sub = 1'b1;
                end else begin
                    w_sel       = {r_tens, r_rem[3:0]};
                    w_load      = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_STROBE;
            end
            S_STROBE: begin
                if (r_cnt == NOTI_LAST) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pending flags: a new pulse wins over a same-cycle accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_pend  <= 1'b0;
            r_freq_pend <= 1'b0;
            r_spd_pend  <= 1'b0;
            r_spd_reg   <= 8'h00;
        end else begin
            if (i_err_req) begin
                r_err_pend <= 1'b1;
            end else if (w_err_acc) begin
                r_err_pend <= 1'b0;
            end
            if (i_freq_req) begin
                r_freq_pend <= 1'b1;
            end else if (w_freq_acc) begin
                r_freq_pend <= 1'b0;
            end
            if (i_speed_valid) begin
                r_spd_pend <= 1'b1;
                r_spd_reg  <= i_speed_val;
            end else if (w_spd_acc) begin
                r_spd_pend <= 1'b0;
            end
        end
    end

    // BCD conversion datapath. r_first marks the classification cycle,
    // which always directly follows the accept in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem   <= 8'h00;
            r_tens  <= 4'h0;
            r_first <= 1'b0;
        end else begin
            r_first <= w_spd_acc;
            if (w_spd_acc) begin
                r_rem  <= r_spd_reg;
                r_tens <= 4'h0;
            end else if (w_sub) begin
                r_rem  <= r_rem - 8'd10;
                r_tens <= r_tens + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msg <= 8'h00;
        end else if (w_load) begin
            r_msg <= w_sel;
        end
    end

    // Shared STROBE/HOLD duration counter, restarted on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (r_state == S_STROBE || r_state == S_HOLD) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if (r_state == S_IDLE && w_state_nxt != S_IDLE) begin
            r_idle_cnt <= '0;
        end else if (w_idle_inc) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    assign o_msg  = r_msg;
    assign o_noti = (r_state == S_STROBE);
    assign o_busy = (r_state != S_IDLE);

endmodule
